// File: rtl/x74137_strobe_dec.sv
// x74137_strobe_dec: clocked AW-to-2^AW active-low decoder with 74137-style address latch and optional fixed-length strobe
// Ports: clk; reset (synchronous, active high); ce (clock enable for all state);
//        le_n (address latch enable, 0 = transparent); g1 / g2_n (enables); a (select address);
//        o_n (registered active-low decoded outputs); busy (strobe in progress, MODE 1 only).
module x74137_strobe_dec #(
    parameter int AW        = 3,
    parameter int MODE      = 0,
    parameter int PULSE_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               le_n,
    input  logic               g1,
    input  logic               g2_n,
    input  logic [AW-1:0]      a,
    output logic [(1<<AW)-1:0] o_n,
    output logic               busy
);
    localparam int N = 1 << AW;

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    state_t        state_q;
    logic [AW-1:0] a_lat_q, s_addr_q, addr_eff;
    logic [7:0]    cnt_q;
    logic [N-1:0]  o_n_q;
    logic          en;

    // The transparent-latch value is also the next latch content.
    assign addr_eff = le_n ? a_lat_q : a;
    assign en       = g1 & ~g2_n;
    assign o_n      = o_n_q;
    assign busy     = (MODE != 0) && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_lat_q  <= '0;
            s_addr_q <= '0;
            cnt_q    <= '0;
            o_n_q    <= '1;
        end else if (ce) begin
            a_lat_q <= addr_eff;
            if (MODE == 0) begin
                o_n_q <= en ? ~(N'(1) << addr_eff) : '1;
            end else begin
                case (state_q)
                    IDLE: if (en) begin
                        s_addr_q <= addr_eff;
                        cnt_q    <= 8'(PULSE_LEN - 1);
                        o_n_q    <= ~(N'(1) << addr_eff);
                        state_q  <= PULSE;
                    end
                    PULSE: if (cnt_q != 8'd0) begin
                        // Select is rebuilt from the frozen strobe address; bus changes are ignored.
                        cnt_q <= cnt_q - 8'd1;
                        o_n_q <= ~(N'(1) << s_addr_q);
                    end else begin
                        o_n_q   <= '1;
                        state_q <= en ? HOLD : IDLE;
                    end
                    HOLD: if (!en) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_x74137_strobe_dec.sv
// tb_x74137_strobe_dec: randomized and directed checks of level and strobe decoders against a behavioural model
module tb_x74137_strobe_dec;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       le_n = 1'b0;
    logic       g1 = 1'b0;
    logic       g2_n = 1'b1;
    logic [2:0] a = 3'd0;
    logic [7:0] o0, o4, o3, o1;
    logic       b0, b4, b3, b1;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    x74137_strobe_dec #(.AW(3), .MODE(0), .PULSE_LEN(4)) u0 (.clk(clk), .reset(reset), .ce(ce), .le_n(le_n), .g1(g1), .g2_n(g2_n), .a(a), .o_n(o0), .busy(b0));
    x74137_strobe_dec #(.AW(3), .MODE(1), .PULSE_LEN(4)) u4 (.clk(clk), .reset(reset), .ce(ce), .le_n(le_n), .g1(g1), .g2_n(g2_n), .a(a), .o_n(o4), .busy(b4));
    x74137_strobe_dec #(.AW(3), .MODE(1), .PULSE_LEN(3)) u3 (.clk(clk), .reset(reset), .ce(ce), .le_n(le_n), .g1(g1), .g2_n(g2_n), .a(a), .o_n(o3), .busy(b3));
    x74137_strobe_dec #(.AW(3), .MODE(1), .PULSE_LEN(1)) u1 (.clk(clk), .reset(reset), .ce(ce), .le_n(le_n), .g1(g1), .g2_n(g2_n), .a(a), .o_n(o1), .busy(b1));

    // Behavioural model: remaining low cycles per strobe decoder and a "wait for enable to drop" flag.
    localparam int PL[3] = '{4, 3, 1};
    logic [2:0] m_lat = 3'd0;
    logic [7:0] m0 = 8'hFF;
    int         rem[3] = '{0, 0, 0};
    logic [2:0] sadr[3] = '{3'd0, 3'd0, 3'd0};
    logic       wt[3] = '{1'b0, 1'b0, 1'b0};
    logic [2:0] m_eff;
    logic       m_en;
    logic [7:0] os[3];
    logic       bs[3];

    assign m_eff = le_n ? m_lat : a;
    assign m_en  = g1 && !g2_n;
    assign os[0] = o4;
    assign os[1] = o3;
    assign os[2] = o1;
    assign bs[0] = b4;
    assign bs[1] = b3;
    assign bs[2] = b1;

    function automatic logic [7:0] sel_n(input logic [2:0] ad);
        logic [7:0] r;
        r = 8'hFF;
        r[ad] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_lat <= 3'd0;
            m0    <= 8'hFF;
            for (int k = 0; k < 3; k++) begin
                rem[k]  <= 0;
                sadr[k] <= 3'd0;
                wt[k]   <= 1'b0;
            end
        end else if (ce) begin
            m_lat <= m_eff;
            m0    <= m_en ? sel_n(m_eff) : 8'hFF;
            for (int k = 0; k < 3; k++) begin
                if (rem[k] > 0) begin
                    rem[k] <= rem[k] - 1;
                    if (rem[k] == 1) wt[k] <= m_en;
                end else if (wt[k]) begin
                    wt[k] <= m_en;
                end else if (m_en) begin
                    rem[k]  <= PL[k];
                    sadr[k] <= m_eff;
                end
            end
        end
    end

    function automatic logic [7:0] exp_o(input int k);
        return (rem[k] > 0) ? sel_n(sadr[k]) : 8'hFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        g1 = 1'b0;
        g2_n = 1'b0;
        ce = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce = 1'b0;
        g1 = 1'b1;
        g2_n = 1'b0;
        a = 3'd4;
        tick();
        tick();
        total++;
        if ({o0, o4, o3, o1} !== {4{8'hFF}}) $display("FAIL reset_o_n: got %h %h %h %h want ff each", o0, o4, o3, o1);
        else pass_cnt++;
        total++;
        if ({b0, b4, b3, b1} !== 4'b0000) $display("FAIL reset_busy: got %b want 0000", {b0, b4, b3, b1});
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_mode0_sweep();
        logic [7:0] e;
        ce = 1'b1;
        g1 = 1'b1;
        g2_n = 1'b0;
        le_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            tick();
            e = 8'hFF;
            e[i] = 1'b0;
            total++;
            if (o0 !== e || o0 !== m0) $display("FAIL sweep_a%0d: got %h want %h", i, o0, e);
            else pass_cnt++;
        end
        g2_n = 1'b1;
        tick();
        total++;
        if (o0 !== 8'hFF) $display("FAIL sweep_disable: got %h want ff", o0);
        else pass_cnt++;
    endtask

    task automatic test_latch_hold();
        g2_n = 1'b0;
        le_n = 1'b0;
        a = 3'd5;
        tick();
        le_n = 1'b1;
        a = 3'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (o0 !== 8'hDF) $display("FAIL latch_hold%0d: got %h want df", i, o0);
            else pass_cnt++;
        end
        le_n = 1'b0;
        tick();
        total++;
        if (o0 !== 8'hFB) $display("FAIL latch_open: got %h want fb", o0);
        else pass_cnt++;
    endtask

    task automatic test_strobe_basic();
        logic [7:0] e;
        idle();
        a = 3'd3;
        g1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            e = (c <= 4) ? 8'hF7 : 8'hFF;
            total++;
            if (o4 !== e || b4 !== 1'b1) $display("FAIL strobe_c%0d: got o_n=%h busy=%b want o_n=%h busy=1", c, o4, b4, e);
            else pass_cnt++;
        end
        g1 = 1'b0;
        tick();
        total++;
        if (o4 !== 8'hFF || b4 !== 1'b0) $display("FAIL strobe_release: got o_n=%h busy=%b want ff/0", o4, b4);
        else pass_cnt++;
        g1 = 1'b1;
        tick();
        total++;
        if (o4 !== 8'hF7 || b4 !== 1'b1) $display("FAIL strobe_retrigger: got o_n=%h busy=%b want f7/1", o4, b4);
        else pass_cnt++;
    endtask

    task automatic test_ce_gating();
        int low_clk, low_ce;
        logic was_low;
        idle();
        a = 3'd3;
        g1 = 1'b1;
        tick();
        total++;
        if (o3 !== 8'hF7) $display("FAIL gate_start: got %h want f7", o3);
        else pass_cnt++;
        low_clk = 0;
        low_ce = 0;
        a = 3'd6;
        for (int s = 0; s < 10; s++) begin
            ce = (s % 2) == 1;
            was_low = (o3 !== 8'hFF);
            tick();
            if (was_low) begin
                low_clk++;
                if (ce) low_ce++;
            end
            total++;
            if (o3 !== exp_o(1) || o3 === 8'hBF) $display("FAIL gate_s%0d: got %h want %h", s, o3, exp_o(1));
            else pass_cnt++;
        end
        ce = 1'b1;
        total++;
        if (low_ce !== 3 || low_clk !== 6) $display("FAIL gate_width: got ce=%0d clk=%0d want ce=3 clk=6", low_ce, low_clk);
        else pass_cnt++;
    endtask

    task automatic test_edge_cases();
        idle();
        a = 3'd3;
        g1 = 1'b1;
        tick();
        total++;
        if (o1 !== 8'hF7 || b1 !== 1'b1) $display("FAIL len1_low: got %h/%b want f7/1", o1, b1);
        else pass_cnt++;
        tick();
        total++;
        if (o1 !== 8'hFF || b1 !== 1'b1) $display("FAIL len1_hold: got %h/%b want ff/1", o1, b1);
        else pass_cnt++;
        g1 = 1'b0;
        tick();
        total++;
        if (b1 !== 1'b0) $display("FAIL len1_idle: got busy=%b want 0", b1);
        else pass_cnt++;
        idle();
        g1 = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (o4 !== 8'hFF || b4 !== 1'b0) $display("FAIL reset_mid: got %h/%b want ff/0", o4, b4);
        else pass_cnt++;
        reset = 1'b0;
        idle();
        a = 3'd5;
        g1 = 1'b1;
        tick();
        g1 = 1'b0;
        a = 3'd1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (c < 4 && (o4 !== 8'hDF || b4 !== 1'b1)) $display("FAIL drop_c%0d: got %h/%b want df/1", c, o4, b4);
            else if (c == 4 && (o4 !== 8'hFF || b4 !== 1'b0)) $display("FAIL drop_end: got %h/%b want ff/0", o4, b4);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom % 60) == 0;
            ce = ($urandom % 4) != 0;
            le_n = ($urandom % 3) == 0;
            g1 = ($urandom % 4) != 0;
            g2_n = ($urandom % 5) == 0;
            a = 3'($urandom);
            tick();
            total++;
            if (o0 !== m0 || b0 !== 1'b0) $display("FAIL rand_lvl_%0d: got %h/%b want %h/0", i, o0, b0, m0);
            else pass_cnt++;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (os[k] !== exp_o(k) || bs[k] !== (rem[k] > 0 || wt[k])) $display("FAIL rand_pl%0d_%0d: got %h/%b want %h/%b", PL[k], i, os[k], bs[k], exp_o(k), (rem[k] > 0 || wt[k]));
                else pass_cnt++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mode0_sweep();
        test_latch_hold();
        test_strobe_basic();
        test_ce_gating();
        test_edge_cases();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
